// File: rtl/br_pkg.sv
// Shared opcode/condition constants and uop classification for the branch execution unit.
package br_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;
    localparam logic [2:0] F3_LT  = 3'b100;
    localparam logic [2:0] F3_GE  = 3'b101;
    localparam logic [2:0] F3_LTU = 3'b110;
    localparam logic [2:0] F3_GEU = 3'b111;

    typedef enum logic [1:0] {
        NONE,
        BRANCH,
        JAL,
        JALR
    } br_kind_t;

    function automatic br_kind_t decode_kind(input logic [6:0] uop);
        br_kind_t kind;
        kind = NONE;
        case (uop)
            OP_BRANCH: kind = BRANCH;
            OP_JAL:    kind = JAL;
            OP_JALR:   kind = JALR;
            default:   kind = NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/br_compare.sv
// Combinational B-type condition evaluation; reserved func3 encodings are never taken.
module br_compare
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (func3)
            F3_EQ:   taken = (op1 == op2);
            F3_NE:   taken = (op1 != op2);
            F3_LT:   taken = ($signed(op1) < $signed(op2));
            F3_GE:   taken = ($signed(op1) >= $signed(op2));
            F3_LTU:  taken = (op1 < op2);
            F3_GEU:  taken = (op1 >= op2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_br_pipe.sv
// Two-register branch/jump resolve unit: S1 input register, S2 resolution and link writeback
// register with backpressure, branch-mask kill/clear filtering and a saturating mispredict count.
module execute_br_pipe
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH_REG = 7,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [6:0]           i_uop,
    input  logic [2:0]           i_func3,
    input  logic                 i_rvc,
    input  logic [XLEN-1:0]      i_op1,
    input  logic [XLEN-1:0]      i_op2,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [XLEN-1:0]      i_pc_pred,
    input  logic [WIDTH_BRM-1:0] i_brmask,
    input  logic [WIDTH_BRM-1:0] i_brtag,
    input  logic [WIDTH_REG-1:0] i_rd,
    input  logic [WIDTH_BRM-1:0] i_kill_mask,
    input  logic [WIDTH_BRM-1:0] i_clr_mask,
    output logic                 o_res_valid,
    output logic [WIDTH_BRM-1:0] o_res_tag,
    output logic                 o_brkill,
    output logic [XLEN-1:0]      o_redirect_pc,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [WIDTH_REG-1:0] o_wb_addr,
    output logic [XLEN-1:0]      o_wb_data,
    output logic [CNT_W-1:0]     o_mispred_cnt
);

    typedef struct packed {
        logic                 valid;
        br_kind_t             kind;
        logic [2:0]           func3;
        logic                 rvc;
        logic [XLEN-1:0]      op1;
        logic [XLEN-1:0]      op2;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_pred;
        logic [WIDTH_BRM-1:0] brmask;
        logic [WIDTH_BRM-1:0] brtag;
        logic [WIDTH_REG-1:0] rd;
    } s1_t;

    s1_t                  s1_q, s1_d;
    logic                 res_valid_q, res_valid_d;
    logic                 brkill_q, brkill_d;
    logic [WIDTH_BRM-1:0] res_tag_q, res_tag_d;
    logic [XLEN-1:0]      redirect_q, redirect_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [WIDTH_REG-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic [WIDTH_BRM-1:0] wb_brmask_q, wb_brmask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 stall, s1_killed, transfer, resolve, accept, taken;
    logic [XLEN-1:0]      link, target;
    logic [WIDTH_BRM-1:0] kill_eff;

    br_compare #(.XLEN(XLEN)) u_cmp (
        .func3 (s1_q.func3),
        .op1   (s1_q.op1),
        .op2   (s1_q.op2),
        .taken (taken)
    );

    assign stall     = wb_valid_q & ~i_wb_ready;
    assign o_ready   = ~(s1_q.valid & stall);
    assign accept    = i_valid & o_ready;
    assign s1_killed = |(s1_q.brmask & i_kill_mask);
    assign transfer  = s1_q.valid & ~stall & ~s1_killed;
    assign resolve   = transfer & (s1_q.kind != NONE);
    assign link      = s1_q.rvc ? XLEN'(2) : XLEN'(4);

    always_comb begin
        target = s1_q.pc + link;
        case (s1_q.kind)
            BRANCH:  target = taken ? (s1_q.pc + s1_q.imm) : (s1_q.pc + link);
            JAL:     target = s1_q.pc + s1_q.imm;
            JALR:    target = (s1_q.op1 + s1_q.imm) & ~XLEN'(1);
            default: target = s1_q.pc + link;
        endcase
    end

    always_comb begin
        res_valid_d = resolve;
        brkill_d    = resolve & (target != s1_q.pc_pred);
        res_tag_d   = resolve ? s1_q.brtag : res_tag_q;
        redirect_d  = resolve ? target : redirect_q;
        cnt_d       = (brkill_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        wb_valid_d  = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_brmask_d = wb_brmask_q & ~i_clr_mask;
        // A held writeback can still be squashed by an older mispredict.
        if (stall) begin
            wb_valid_d = ~|(wb_brmask_q & i_kill_mask);
        end else if (resolve && (s1_q.kind == JAL || s1_q.kind == JALR) && s1_q.rd != '0) begin
            wb_valid_d  = 1'b1;
            wb_addr_d   = s1_q.rd;
            wb_data_d   = s1_q.pc + link;
            wb_brmask_d = s1_q.brmask & ~i_clr_mask;
        end
    end

    // A mispredict resolving this edge also squashes any dependent uop entering S1.
    assign kill_eff = i_kill_mask | (brkill_d ? s1_q.brtag : '0);

    always_comb begin
        s1_d        = s1_q;
        s1_d.brmask = s1_q.brmask & ~i_clr_mask;
        if (transfer || s1_killed) begin
            s1_d.valid = 1'b0;
        end
        if (accept) begin
            s1_d.valid   = ~|(i_brmask & kill_eff);
            s1_d.kind    = decode_kind(i_uop);
            s1_d.func3   = i_func3;
            s1_d.rvc     = i_rvc;
            s1_d.op1     = i_op1;
            s1_d.op2     = i_op2;
            s1_d.imm     = i_imm;
            s1_d.pc      = i_pc;
            s1_d.pc_pred = i_pc_pred;
            s1_d.brmask  = i_brmask & ~i_clr_mask;
            s1_d.brtag   = i_brtag;
            s1_d.rd      = i_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q        <= '0;
            res_valid_q <= 1'b0;
            brkill_q    <= 1'b0;
            res_tag_q   <= '0;
            redirect_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_brmask_q <= '0;
            cnt_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            res_valid_q <= res_valid_d;
            brkill_q    <= brkill_d;
            res_tag_q   <= res_tag_d;
            redirect_q  <= redirect_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_brmask_q <= wb_brmask_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_res_valid   = res_valid_q;
    assign o_brkill      = brkill_q;
    assign o_res_tag     = res_tag_q;
    assign o_redirect_pc = redirect_q;
    assign o_wb_valid    = wb_valid_q;
    assign o_wb_addr     = wb_addr_q;
    assign o_wb_data     = wb_data_q;
    assign o_mispred_cnt = cnt_q;

endmodule

// File: tb/tb_execute_br_pipe.sv
// Directed self-checking bench for execute_br_pipe; the counter is narrowed to 2 bits so
// saturation is reachable in a few uops.
module tb_execute_br_pipe;

    localparam logic [6:0] UOP_B    = 7'b1100011;
    localparam logic [6:0] UOP_JAL  = 7'b1101111;
    localparam logic [6:0] UOP_JALR = 7'b1100111;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_rvc, i_wb_ready;
    logic [6:0]  i_uop;
    logic [2:0]  i_func3;
    logic [31:0] i_op1, i_op2, i_imm, i_pc, i_pc_pred;
    logic [3:0]  i_brmask, i_brtag, i_kill_mask, i_clr_mask;
    logic [6:0]  i_rd;
    logic        o_res_valid, o_brkill, o_wb_valid;
    logic [3:0]  o_res_tag;
    logic [31:0] o_redirect_pc, o_wb_data;
    logic [6:0]  o_wb_addr;
    logic [1:0]  o_mispred_cnt;

    int tests = 0;
    int failed = 0;

    execute_br_pipe #(.XLEN(32), .WIDTH_BRM(4), .WIDTH_REG(7), .CNT_W(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_uop(i_uop), .i_func3(i_func3), .i_rvc(i_rvc), .i_op1(i_op1), .i_op2(i_op2),
        .i_imm(i_imm), .i_pc(i_pc), .i_pc_pred(i_pc_pred), .i_brmask(i_brmask),
        .i_brtag(i_brtag), .i_rd(i_rd), .i_kill_mask(i_kill_mask), .i_clr_mask(i_clr_mask),
        .o_res_valid(o_res_valid), .o_res_tag(o_res_tag), .o_brkill(o_brkill),
        .o_redirect_pc(o_redirect_pc), .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_mispred_cnt(o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_uop = 0; i_func3 = 0; i_rvc = 0; i_op1 = 0; i_op2 = 0;
        i_imm = 0; i_pc = 0; i_pc_pred = 0; i_brmask = 0; i_brtag = 0; i_rd = 0;
        i_kill_mask = 0; i_clr_mask = 0;
    endtask

    task automatic offer(input logic [6:0] uop, input logic [2:0] f3, input logic rvc,
                         input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] pred,
                         input logic [3:0] brmask, input logic [3:0] brtag, input logic [6:0] rd);
        i_valid = 1; i_uop = uop; i_func3 = f3; i_rvc = rvc; i_op1 = op1; i_op2 = op2;
        i_imm = imm; i_pc = pc; i_pc_pred = pred; i_brmask = brmask; i_brtag = brtag; i_rd = rd;
    endtask

    task automatic test_reset();
        idle(); i_wb_ready = 1; i_rst = 1;
        tick(); tick();
        tests++; if (o_res_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_res_valid: got %0b want 0", o_res_valid); end
        tests++; if (o_brkill !== 1'b0) begin failed++; $display("[TB] FAIL reset_brkill: got %0b want 0", o_brkill); end
        tests++; if (o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_wb_valid: got %0b want 0", o_wb_valid); end
        tests++; if (o_mispred_cnt !== 2'd0) begin failed++; $display("[TB] FAIL reset_cnt: got %0d want 0", o_mispred_cnt); end
        i_rst = 0;
        tests++; if (o_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_ready: got %0b want 1", o_ready); end
    endtask

    task automatic test_beq_mispredict();
        offer(UOP_B, 3'b000, 0, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104, 4'b0000, 4'b0001, 7'd0);
        tick(); idle();
        tests++; if (o_res_valid !== 1'b0) begin failed++; $display("[TB] FAIL beq_latency: got %0b want 0", o_res_valid); end
        tick();
        tests++; if (o_res_valid !== 1'b1) begin failed++; $display("[TB] FAIL beq_res_valid: got %0b want 1", o_res_valid); end
        tests++; if (o_res_tag !== 4'b0001) begin failed++; $display("[TB] FAIL beq_tag: got %b want 0001", o_res_tag); end
        tests++; if (o_brkill !== 1'b1) begin failed++; $display("[TB] FAIL beq_brkill: got %0b want 1", o_brkill); end
        tests++; if (o_redirect_pc !== 32'h120) begin failed++; $display("[TB] FAIL beq_redirect: got %h want 00000120", o_redirect_pc); end
        tests++; if (o_mispred_cnt !== 2'd1) begin failed++; $display("[TB] FAIL beq_cnt: got %0d want 1", o_mispred_cnt); end
        tests++; if (o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL beq_no_wb: got %0b want 0", o_wb_valid); end
        tick();
        tests++; if (o_res_valid !== 1'b0 || o_brkill !== 1'b0) begin failed++; $display("[TB] FAIL beq_pulse: got res=%0b kill=%0b want 0/0", o_res_valid, o_brkill); end
    endtask

    task automatic test_branch_conditions();
        logic [2:0]  f3  [6];
        logic [31:0] op1 [6];
        logic [31:0] op2 [6];
        logic [31:0] pc  [6];
        logic [31:0] imm [6];
        logic [31:0] prd [6];
        logic [31:0] exp_tgt [6];
        logic        exp_kill [6];
        // bne-equal, blt signed, bltu unsigned, bge signed, reserved 010, bgeu with negative imm
        f3  = '{3'b001, 3'b100, 3'b110, 3'b101, 3'b010, 3'b111};
        op1 = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
        op2 = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd3, 32'd1};
        pc  = '{32'h300, 32'h400, 32'h400, 32'h500, 32'h600, 32'h700};
        imm = '{32'h40, 32'h10, 32'h10, 32'h10, 32'h10, 32'hFFFFFFF0};
        prd = '{32'h304, 32'h410, 32'h410, 32'h504, 32'h604, 32'h6F0};
        exp_tgt  = '{32'h304, 32'h410, 32'h404, 32'h504, 32'h604, 32'h6F0};
        exp_kill = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int v = 0; v < 6; v++) begin
            offer(UOP_B, f3[v], 0, op1[v], op2[v], imm[v], pc[v], prd[v], 4'b0000, 4'b0100, 7'd0);
            tick(); idle(); tick();
            tests++; if (o_res_valid !== 1'b1 || o_brkill !== exp_kill[v]) begin failed++; $display("[TB] FAIL cond%0d_kill: got res=%0b kill=%0b want 1/%0b", v, o_res_valid, o_brkill, exp_kill[v]); end
            tests++; if (o_redirect_pc !== exp_tgt[v]) begin failed++; $display("[TB] FAIL cond%0d_target: got %h want %h", v, o_redirect_pc, exp_tgt[v]); end
        end
        tests++; if (o_mispred_cnt !== 2'd2) begin failed++; $display("[TB] FAIL cond_cnt: got %0d want 2", o_mispred_cnt); end
    endtask

    task automatic test_jalr_link();
        offer(UOP_JALR, 3'b000, 1, 32'h201, 32'd0, 32'd0, 32'h500, 32'h200, 4'b0000, 4'b0010, 7'd3);
        tick(); idle(); tick();
        tests++; if (o_res_valid !== 1'b1 || o_brkill !== 1'b0) begin failed++; $display("[TB] FAIL jalr_res: got res=%0b kill=%0b want 1/0", o_res_valid, o_brkill); end
        tests++; if (o_redirect_pc !== 32'h200) begin failed++; $display("[TB] FAIL jalr_target: got %h want 00000200", o_redirect_pc); end
        tests++; if (o_wb_valid !== 1'b1 || o_wb_addr !== 7'd3) begin failed++; $display("[TB] FAIL jalr_wb: got v=%0b rd=%0d want 1/3", o_wb_valid, o_wb_addr); end
        tests++; if (o_wb_data !== 32'h502) begin failed++; $display("[TB] FAIL jalr_link: got %h want 00000502", o_wb_data); end
        tick();
        tests++; if (o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL jalr_wb_drain: got %0b want 0", o_wb_valid); end
    endtask

    task automatic test_back_to_back();
        i_wb_ready = 0;
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h100, 32'h600, 32'h700, 4'b0000, 4'b0001, 7'd5);
        tick();
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h8, 32'h700, 32'h708, 4'b0000, 4'b0010, 7'd6);
        tests++; if (o_ready !== 1'b1) begin failed++; $display("[TB] FAIL bp_ready_first: got %0b want 1", o_ready); end
        tick(); idle();
        tests++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'b0001) begin failed++; $display("[TB] FAIL bp_res_a: got res=%0b tag=%b want 1/0001", o_res_valid, o_res_tag); end
        tests++; if (o_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_ready_full: got %0b want 0", o_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h604 || o_wb_addr !== 7'd5) begin failed++; $display("[TB] FAIL bp_hold%0d: got v=%0b rd=%0d data=%h want 1/5/00000604", c, o_wb_valid, o_wb_addr, o_wb_data); end
            tests++; if (o_res_valid !== 1'b0 || o_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_stall%0d: got res=%0b ready=%0b want 0/0", c, o_res_valid, o_ready); end
        end
        i_wb_ready = 1;
        tick();
        tests++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'b0010) begin failed++; $display("[TB] FAIL bp_res_b: got res=%0b tag=%b want 1/0010", o_res_valid, o_res_tag); end
        tests++; if (o_wb_valid !== 1'b1 || o_wb_addr !== 7'd6 || o_wb_data !== 32'h704) begin failed++; $display("[TB] FAIL bp_wb_b: got v=%0b rd=%0d data=%h want 1/6/00000704", o_wb_valid, o_wb_addr, o_wb_data); end
        tick();
        tests++; if (o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL bp_drain: got %0b want 0", o_wb_valid); end
    endtask

    task automatic test_ext_kill();
        i_wb_ready = 0;
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h4, 32'h800, 32'h804, 4'b0010, 4'b0001, 7'd7);
        tick(); idle(); tick();
        tests++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h804) begin failed++; $display("[TB] FAIL kill_wb_pending: got v=%0b data=%h want 1/00000804", o_wb_valid, o_wb_data); end
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h4, 32'h900, 32'h904, 4'b0010, 4'b0100, 7'd8);
        i_kill_mask = 4'b0010;
        tick(); idle(); i_wb_ready = 1;
        tests++; if (o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL kill_wb_drop: got %0b want 0", o_wb_valid); end
        tick();
        tests++; if (o_res_valid !== 1'b0 || o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL kill_input_drop: got res=%0b wb=%0b want 0/0", o_res_valid, o_wb_valid); end
    endtask

    task automatic test_self_kill();
        offer(UOP_B, 3'b000, 0, 32'd9, 32'd9, 32'h10, 32'h900, 32'h904, 4'b0000, 4'b0001, 7'd0);
        tick();
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h4, 32'h910, 32'h914, 4'b0001, 4'b0010, 7'd9);
        tick(); idle();
        tests++; if (o_brkill !== 1'b1 || o_res_tag !== 4'b0001 || o_redirect_pc !== 32'h910) begin failed++; $display("[TB] FAIL self_kill_res: got kill=%0b tag=%b pc=%h want 1/0001/00000910", o_brkill, o_res_tag, o_redirect_pc); end
        tests++; if (o_mispred_cnt !== 2'd3) begin failed++; $display("[TB] FAIL self_kill_cnt: got %0d want 3", o_mispred_cnt); end
        tick();
        tests++; if (o_res_valid !== 1'b0 || o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL self_kill_younger: got res=%0b wb=%0b want 0/0", o_res_valid, o_wb_valid); end
    endtask

    task automatic test_saturation_and_reset();
        i_rst = 1; tick(); i_rst = 0;
        tests++; if (o_mispred_cnt !== 2'd0) begin failed++; $display("[TB] FAIL sat_cnt_clear: got %0d want 0", o_mispred_cnt); end
        for (int u = 0; u < 5; u++) begin
            offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h40, 32'h1000 + 32'(u * 16), 32'h1004 + 32'(u * 16), 4'b0000, 4'b0001, 7'd0);
            tick();
        end
        idle(); tick();
        tests++; if (o_mispred_cnt !== 2'd3) begin failed++; $display("[TB] FAIL sat_cnt: got %0d want 3", o_mispred_cnt); end
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h8, 32'h2000, 32'h2008, 4'b0000, 4'b0001, 7'd4);
        tick();
        offer(UOP_JAL, 3'b000, 0, 32'd0, 32'd0, 32'h8, 32'h2100, 32'h2108, 4'b0000, 4'b0010, 7'd5);
        tick(); idle();
        tests++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h2004) begin failed++; $display("[TB] FAIL rst_pre_wb: got v=%0b data=%h want 1/00002004", o_wb_valid, o_wb_data); end
        i_rst = 1; tick(); i_rst = 0;
        tests++; if (o_res_valid !== 1'b0 || o_brkill !== 1'b0 || o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_valids: got res=%0b kill=%0b wb=%0b want 0/0/0", o_res_valid, o_brkill, o_wb_valid); end
        tests++; if (o_res_tag !== 4'd0 || o_redirect_pc !== 32'd0 || o_wb_addr !== 7'd0 || o_wb_data !== 32'd0) begin failed++; $display("[TB] FAIL rst_mid_data: got tag=%b pc=%h rd=%0d data=%h want all 0", o_res_tag, o_redirect_pc, o_wb_addr, o_wb_data); end
        tests++; if (o_mispred_cnt !== 2'd0 || o_ready !== 1'b1) begin failed++; $display("[TB] FAIL rst_mid_cnt_ready: got cnt=%0d ready=%0b want 0/1", o_mispred_cnt, o_ready); end
        tick();
        tests++; if (o_res_valid !== 1'b0 || o_wb_valid !== 1'b0) begin failed++; $display("[TB] FAIL rst_discard: got res=%0b wb=%0b want 0/0", o_res_valid, o_wb_valid); end
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_branch_conditions();
        test_jalr_link();
        test_back_to_back();
        test_ext_kill();
        test_self_kill();
        test_saturation_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/execute_br_pipe.md
Name: execute_br_pipe

Overview:
Second-generation branch/jump execution unit for the out-of-order core. It resolves B-type, JAL and JALR uops in a two-register pipeline: an input register (S1) feeding a resolve/output register (S2). It compares the computed target against the predicted next PC, emits a one-hot branch kill/clear, and writes the link value back. New in this generation: valid/ready handshake with writeback backpressure, external kill/clear filtering of in-flight branch masks, RVC link (+2), JALR bit-0 masking, and a saturating mispredict counter.

Parameters:
XLEN, 32, datapath and PC width
WIDTH_BRM, 4, branch-mask width; one bit per in-flight branch tag
WIDTH_REG, 7, physical register address width
CNT_W, 16, mispredict counter width

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  uop offered
o_ready  out  1  unit can accept the offered uop this cycle
i_uop  in  7  opcode
i_func3  in  3  branch condition
i_rvc  in  1  compressed instruction; link = PC+2
i_op1, i_op2  in  XLEN  rs1/rs2 values
i_imm  in  XLEN  sign-extended immediate
i_pc  in  XLEN  uop PC
i_pc_pred  in  XLEN  predicted next PC
i_brmask  in  WIDTH_BRM  older branches this uop depends on
i_brtag  in  WIDTH_BRM  one-hot tag of this branch
i_rd  in  WIDTH_REG  destination physical register
i_kill_mask  in  WIDTH_BRM  tags killed elsewhere this cycle
i_clr_mask  in  WIDTH_BRM  tags resolved correct elsewhere this cycle
o_res_valid  out  1  resolution pulse
o_res_tag  out  WIDTH_BRM  tag being resolved
o_brkill  out  1  mispredict; o_res_tag is killed
o_redirect_pc  out  XLEN  correct target, valid with o_brkill
o_wb_valid  out  1  link writeback pending
i_wb_ready  in  1  writeback accepted
o_wb_addr  out  WIDTH_REG  link register address
o_wb_data  out  XLEN  link value
o_mispred_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (i_rst=1 at a rising edge): S1/S2 invalid; o_res_valid, o_brkill, o_wb_valid=0; o_res_tag, o_redirect_pc, o_wb_addr, o_wb_data=0; o_mispred_cnt=0. o_ready=1 in the first cycle after reset. A reset mid-operation discards all in-flight uops.
- Stall = o_wb_valid & ~i_wb_ready. o_ready = ~(S1 valid & stall).
- Accept = i_valid & o_ready. Capture into S1 unless (i_brmask & i_kill_mask) != 0; in that case drop the uop silently. Stored brmask = i_brmask & ~i_clr_mask.
- Each edge: any valid S1/S2 entry whose brmask intersects i_kill_mask is invalidated. Valid entries clear i_clr_mask bits from their brmask.
- S1 to S2 transfer happens when S1 is valid and there is no stall. Latency: a uop accepted at edge k has its resolution visible after edge k+1.
- Decode in S1:
  - 1100011 = B: taken per func3 (000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu, 010/011 never taken). Target = taken ? pc+imm : pc+link.
  - 1101111 = JAL: target = pc+imm.
  - 1100111 = JALR: target = (op1+imm) & ~1.
  - Other uops: consumed; no resolution, no writeback.
- link = rvc ? 2 : 4. All arithmetic is modulo 2^XLEN.
- On transfer of a branch/jump: o_res_valid=1 for one cycle, o_res_tag=brtag, o_brkill = (target != pc_pred), o_redirect_pc = target. o_mispred_cnt increments on o_brkill and saturates at all-ones.
- Self-kill: when o_brkill is produced at edge k+1, the same edge invalidates a newly accepted S1 entry whose brmask has the brtag bit. Such an input is dropped.
- Writeback: JAL/JALR with rd != 0 sets o_wb_valid with o_wb_data = pc+link. It holds until i_wb_ready, or until killed by i_kill_mask, which drops it without a pulse.
- Resolution pulses are never stalled. They fire only on a transfer.

Decomposition:
- Shared package br_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - func3 constants
  - br_kind_t enum {NONE, BRANCH, JAL, JALR}
- Sub-module br_compare: combinational condition evaluation from func3, op1, op2 to taken.

Test Plan:
- BEQ: op1=op2=5, pc=0x100, imm=0x20, pred=0x104 -> o_brkill=1, redirect 0x120, cnt=1, no wb.
- JALR rd=3: op1=0x201, imm=0, rvc=1, pred=0x200 -> no kill, wb 0x(pc+2) to rd=3 after 2 edges.
- Backpressure: JAL wb with i_wb_ready=0 for 3 cycles, second uop queued -> o_ready=0 while S1 full; wb data stable; drains in order.
- External kill: S2 wb pending with brmask=0010, i_kill_mask=0010 -> o_wb_valid drops next edge; input with mask 0010 that cycle not captured.
- Self-kill: mispredict tag 0001 resolves while a uop with brmask 0001 enters S1 -> younger invalidated; no res pulse for it.
- Counter saturation: CNT_W=2, 5 mispredicts -> o_mispred_cnt=3; i_rst mid-stream -> all outputs 0 next cycle.
